// File: rtl/glitch_sequencer.sv
// glitch_sequencer
//
// Generates a programmable burst of glitch pulses on the select input of an
// external clock mux. The burst starts a fixed delay after a rising edge on the
// data-valid trigger. It consists of R pulses, each W cycles long, with G-cycle
// gaps between them. While a pulse is active the mux select carries the
// configured source code. At all other times it is 0, which selects the clean
// clock.
//
// Ports
//   clk_in1        system clock, rising edge
//   rst            synchronous active-high reset
//   cfg_valid      config write strobe, accepted only while idle
//   cfg_ready      high while idle, so a config write is taken this cycle
//   cfg_delay      trigger-to-first-pulse delay D (0 is legal)
//   cfg_width      pulse width W (0 is treated as 1)
//   cfg_gap        gap G between pulses (0 is treated as 1)
//   cfg_repeat     pulse count R (0 is treated as 1)
//   cfg_sel        mux code driven during pulses
//   arm            single-cycle arm request
//   abort          cancels a running sequence; takes effect at the next edge
//   trig           trigger level; a rising edge starts an armed sequence
//   glitch_sel     mux select, 0 outside pulses
//   glitch_active  glitch_sel != 0
//   busy           sequencer not idle
//   done           one-cycle pulse when the burst completes
//   pulse_cnt      pulses issued in the current or last sequence
//   overrun        sticky: a trigger edge arrived while sequencing
//   missed_cnt     saturating count of trigger edges that were ignored

module glitch_sequencer #(
  parameter int SEL_W = 2,
  parameter int DLY_W = 16,
  parameter int WID_W = 8,
  parameter int GAP_W = 8,
  parameter int REP_W = 4,
  parameter int OVR_W = 8
) (
  input  logic             clk_in1,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [WID_W-1:0] cfg_width,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig,
  output logic [SEL_W-1:0] glitch_sel,
  output logic             glitch_active,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] pulse_cnt,
  output logic             overrun,
  output logic [OVR_W-1:0] missed_cnt
);

  // One down-counter serves the delay, width and gap phases.
  localparam int CW1   = (DLY_W > WID_W) ? DLY_W : WID_W;
  localparam int CNT_W = (CW1 > GAP_W) ? CW1 : GAP_W;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    PULSE,
    GAP,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trig_q;

  logic [DLY_W-1:0]   cfg_delay_q, cfg_delay_d;
  logic [WID_W-1:0]   cfg_width_q, cfg_width_d;
  logic [GAP_W-1:0]   cfg_gap_q, cfg_gap_d;
  logic [REP_W-1:0]   cfg_repeat_q, cfg_repeat_d;
  logic [SEL_W-1:0]   cfg_sel_q, cfg_sel_d;

  logic [SEL_W-1:0]   glitch_sel_q, glitch_sel_d;
  logic               glitch_active_q, glitch_active_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [REP_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic               overrun_q, overrun_d;
  logic [OVR_W-1:0]   missed_q, missed_d;

  logic               trig_edge;
  logic               sequencing;
  logic [CNT_W-1:0]   w_load;
  logic [CNT_W-1:0]   g_load;
  logic [REP_W-1:0]   r_eff;
  logic [REP_W-1:0]   pulse_inc;

  assign trig_edge  = trig & ~trig_q;
  assign sequencing = (state_q == DELAY) || (state_q == PULSE) ||
                      (state_q == GAP)   || (state_q == DONE);

  // The counter is loaded with the phase length minus one. A zero field behaves
  // like 1, so its load value is also 0.
  assign w_load    = (cfg_width_q == '0) ? '0 : CNT_W'(cfg_width_q) - CNT_W'(1);
  assign g_load    = (cfg_gap_q == '0)   ? '0 : CNT_W'(cfg_gap_q) - CNT_W'(1);
  assign r_eff     = (cfg_repeat_q == '0) ? REP_W'(1) : cfg_repeat_q;
  assign pulse_inc = pulse_cnt_q + REP_W'(1);

  assign cfg_ready = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    overrun_d    = overrun_q;
    missed_d     = missed_q;
    cfg_delay_d  = cfg_delay_q;
    cfg_width_d  = cfg_width_q;
    cfg_gap_d    = cfg_gap_q;
    cfg_repeat_d = cfg_repeat_q;
    cfg_sel_d    = cfg_sel_q;

    if ((state_q == IDLE) && cfg_valid) begin
      cfg_delay_d  = cfg_delay;
      cfg_width_d  = cfg_width;
      cfg_gap_d    = cfg_gap;
      cfg_repeat_d = cfg_repeat;
      cfg_sel_d    = cfg_sel;
    end

    if (trig_edge && sequencing) begin
      overrun_d = 1'b1;
      if (missed_q != '1) begin
        missed_d = missed_q + OVR_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d     = ARMED;
          pulse_cnt_d = '0;
          overrun_d   = 1'b0;
          missed_d    = '0;
        end
      end
      ARMED: begin
        if (trig_edge) begin
          state_d = DELAY;
          cnt_d   = CNT_W'(cfg_delay_q);
        end
      end
      DELAY: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = w_load;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          pulse_cnt_d = pulse_inc;
          if (pulse_inc == r_eff) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            cnt_d   = g_load;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = w_load;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition. pulse_cnt keeps the count of pulses
    // that completed before the abort.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      pulse_cnt_d = pulse_cnt_q;
    end
  end

  // The registered outputs are derived from the next state, so they change on
  // the same edge as the state transition.
  always_comb begin
    glitch_sel_d    = (state_d == PULSE) ? cfg_sel_q : '0;
    glitch_active_d = (glitch_sel_d != '0);
    busy_d          = (state_d != IDLE);
    done_d          = (state_d == DONE);
  end

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      trig_q          <= 1'b0;
      cfg_delay_q     <= '0;
      cfg_width_q     <= '0;
      cfg_gap_q       <= '0;
      cfg_repeat_q    <= '0;
      cfg_sel_q       <= '0;
      glitch_sel_q    <= '0;
      glitch_active_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pulse_cnt_q     <= '0;
      overrun_q       <= 1'b0;
      missed_q        <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      trig_q          <= trig;
      cfg_delay_q     <= cfg_delay_d;
      cfg_width_q     <= cfg_width_d;
      cfg_gap_q       <= cfg_gap_d;
      cfg_repeat_q    <= cfg_repeat_d;
      cfg_sel_q       <= cfg_sel_d;
      glitch_sel_q    <= glitch_sel_d;
      glitch_active_q <= glitch_active_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pulse_cnt_q     <= pulse_cnt_d;
      overrun_q       <= overrun_d;
      missed_q        <= missed_d;
    end
  end

  assign glitch_sel    = glitch_sel_q;
  assign glitch_active = glitch_active_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pulse_cnt     = pulse_cnt_q;
  assign overrun       = overrun_q;
  assign missed_cnt    = missed_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed testbench for glitch_sequencer. A second instance with a 2-bit
// missed-trigger counter shares the stimulus so that saturation can be observed.

module tb_glitch_sequencer;

  localparam int SEL_W = 2;
  localparam int DLY_W = 16;
  localparam int WID_W = 8;
  localparam int GAP_W = 8;
  localparam int REP_W = 4;
  localparam int OVR_W = 8;

  logic             clk_in1;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DLY_W-1:0] cfg_delay;
  logic [WID_W-1:0] cfg_width;
  logic [GAP_W-1:0] cfg_gap;
  logic [REP_W-1:0] cfg_repeat;
  logic [SEL_W-1:0] cfg_sel;
  logic             arm;
  logic             abort;
  logic             trig;
  logic [SEL_W-1:0] glitch_sel;
  logic             glitch_active;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] pulse_cnt;
  logic             overrun;
  logic [OVR_W-1:0] missed_cnt;

  logic             s_cfg_ready;
  logic [SEL_W-1:0] s_glitch_sel;
  logic             s_glitch_active;
  logic             s_busy;
  logic             s_done;
  logic [REP_W-1:0] s_pulse_cnt;
  logic             s_overrun;
  logic [1:0]       s_missed_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  glitch_sequencer #(
    .SEL_W(SEL_W), .DLY_W(DLY_W), .WID_W(WID_W),
    .GAP_W(GAP_W), .REP_W(REP_W), .OVR_W(OVR_W)
  ) u_dut (
    .clk_in1(clk_in1), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
    .cfg_repeat(cfg_repeat), .cfg_sel(cfg_sel),
    .arm(arm), .abort(abort), .trig(trig),
    .glitch_sel(glitch_sel), .glitch_active(glitch_active),
    .busy(busy), .done(done), .pulse_cnt(pulse_cnt),
    .overrun(overrun), .missed_cnt(missed_cnt)
  );

  glitch_sequencer #(
    .SEL_W(SEL_W), .DLY_W(DLY_W), .WID_W(WID_W),
    .GAP_W(GAP_W), .REP_W(REP_W), .OVR_W(2)
  ) u_sat (
    .clk_in1(clk_in1), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
    .cfg_repeat(cfg_repeat), .cfg_sel(cfg_sel),
    .arm(arm), .abort(abort), .trig(trig),
    .glitch_sel(s_glitch_sel), .glitch_active(s_glitch_active),
    .busy(s_busy), .done(s_done), .pulse_cnt(s_pulse_cnt),
    .overrun(s_overrun), .missed_cnt(s_missed_cnt)
  );

  initial clk_in1 = 1'b0;
  always #5 clk_in1 = ~clk_in1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in1);
      #1;
    end
  endtask

  task automatic set_cfg(input int d, input int w, input int g, input int r, input int s);
    cfg_delay  = DLY_W'(d);
    cfg_width  = WID_W'(w);
    cfg_gap    = GAP_W'(g);
    cfg_repeat = REP_W'(r);
    cfg_sel    = SEL_W'(s);
    cfg_valid  = 1'b1;
    step(1);
    cfg_valid  = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  int basic_sel [11] = '{0, 0, 0, 0, 2, 2, 0, 2, 2, 0, 0};
  logic seen_done;

  initial begin
    // Reset with arm, trig and cfg_valid all asserted
    rst = 1'b1; cfg_valid = 1'b1; arm = 1'b1; abort = 1'b0; trig = 1'b1;
    cfg_delay = 9; cfg_width = 4; cfg_gap = 4; cfg_repeat = 3; cfg_sel = 1;
    step(3);
    chk("rst_glitch_sel", int'(glitch_sel), 0);
    chk("rst_active", int'(glitch_active), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pulse_cnt", int'(pulse_cnt), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_missed", int'(missed_cnt), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    rst = 1'b0; cfg_valid = 1'b0; arm = 1'b0; trig = 1'b0;
    step(1);
    chk("post_rst_busy", int'(busy), 0);

    // Basic burst D=3 W=2 G=1 R=2 sel=2
    set_cfg(3, 2, 1, 2, 2);
    do_arm();
    chk("basic_armed_busy", int'(busy), 1);
    chk("basic_armed_ready", int'(cfg_ready), 0);
    trig = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      step(1);
      chk($sformatf("basic_sel_E%0d", e), int'(glitch_sel), basic_sel[e]);
      chk($sformatf("basic_act_E%0d", e), int'(glitch_active), (basic_sel[e] != 0) ? 1 : 0);
      chk($sformatf("basic_done_E%0d", e), int'(done), (e == 9) ? 1 : 0);
    end
    chk("basic_busy_E10", int'(busy), 0);
    chk("basic_pulse_cnt", int'(pulse_cnt), 2);

    // Zero fields, armed while trig is already high
    set_cfg(0, 0, 0, 0, 3);
    do_arm();
    step(3);
    chk("held_trig_busy", int'(busy), 1);
    chk("held_trig_sel", int'(glitch_sel), 0);
    trig = 1'b0;
    step(1);
    trig = 1'b1;
    step(1);
    chk("zero_sel_E0", int'(glitch_sel), 0);
    step(1);
    chk("zero_sel_E1", int'(glitch_sel), 3);
    chk("zero_act_E1", int'(glitch_active), 1);
    step(1);
    chk("zero_sel_E2", int'(glitch_sel), 0);
    chk("zero_done_E2", int'(done), 1);
    chk("zero_pulse_cnt", int'(pulse_cnt), 1);
    step(1);
    chk("zero_busy_E3", int'(busy), 0);
    chk("zero_done_E3", int'(done), 0);

    // Abort in the fourth pulse cycle; arm+abort in IDLE arms
    trig = 1'b0;
    step(1);
    set_cfg(0, 10, 0, 1, 1);
    arm = 1'b1; abort = 1'b1;
    step(1);
    arm = 1'b0; abort = 1'b0;
    chk("arm_beats_abort", int'(busy), 1);
    trig = 1'b1;
    step(1);
    step(4);
    chk("abort_pre_sel", int'(glitch_sel), 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_sel", int'(glitch_sel), 0);
    chk("abort_ready", int'(cfg_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_pulse_cnt", int'(pulse_cnt), 0);
    seen_done = done;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen_done = seen_done | done;
    end
    chk("abort_no_done", int'(seen_done), 0);

    // Overrun: three extra edges during DELAY
    trig = 1'b0;
    step(1);
    set_cfg(5, 1, 0, 1, 1);
    do_arm();
    trig = 1'b1;
    step(1);
    for (int k = 1; k <= 6; k++) begin
      trig = (k % 2 == 0);
      step(1);
    end
    step(2);
    chk("ovr_busy", int'(busy), 0);
    chk("ovr_pulse_cnt", int'(pulse_cnt), 1);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_missed", int'(missed_cnt), 3);
    chk("ovr_missed_w2", int'(s_missed_cnt), 3);
    trig = 1'b0;
    step(1);
    do_arm();
    chk("rearm_overrun", int'(overrun), 0);
    chk("rearm_missed", int'(missed_cnt), 0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("armed_abort_busy", int'(busy), 0);

    // Six extra edges: 8-bit counter reads 6, 2-bit counter saturates at 3
    set_cfg(20, 1, 0, 1, 1);
    do_arm();
    trig = 1'b1;
    step(1);
    for (int k = 1; k <= 12; k++) begin
      trig = (k % 2 == 0);
      step(1);
    end
    trig = 1'b0;
    step(15);
    chk("sat_busy", int'(busy), 0);
    chk("sat_missed_w8", int'(missed_cnt), 6);
    chk("sat_missed_w2", int'(s_missed_cnt), 3);
    chk("sat_overrun_w2", int'(s_overrun), 1);
    chk("sat_busy_w2", int'(s_busy), 0);
    chk("sat_pulse_cnt_w2", int'(s_pulse_cnt), 1);

    // cfg_valid while busy is ignored
    set_cfg(2, 1, 0, 1, 1);
    do_arm();
    trig = 1'b1;
    step(1);
    cfg_delay = 7; cfg_valid = 1'b1;
    chk("busy_ready", int'(cfg_ready), 0);
    step(1);
    cfg_valid = 1'b0;
    chk("ign_sel_E1", int'(glitch_sel), 0);
    step(1);
    chk("ign_sel_E2", int'(glitch_sel), 0);
    step(1);
    chk("ign_sel_E3", int'(glitch_sel), 1);
    step(3);
    chk("ign_idle", int'(busy), 0);
    trig = 1'b0;
    step(1);

    // cfg_valid and arm together: new D=1 applies
    cfg_delay = 1; cfg_width = 1; cfg_gap = 0; cfg_repeat = 1; cfg_sel = 2;
    cfg_valid = 1'b1; arm = 1'b1;
    step(1);
    cfg_valid = 1'b0; arm = 1'b0;
    trig = 1'b1;
    step(1);
    step(1);
    chk("cfgarm_sel_E1", int'(glitch_sel), 0);
    step(1);
    chk("cfgarm_sel_E2", int'(glitch_sel), 2);
    chk("cfgarm_sel_E2_w2", int'(s_glitch_sel), 2);
    chk("cfgarm_act_E2_w2", int'(s_glitch_active), 1);
    step(2);
    chk("cfgarm_done_w2", int'(s_done), 0);
    chk("cfgarm_ready_w2", int'(s_cfg_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
